addr_fifo_sched: RTL and testbench

ADDR_FIFO_SCHED -- requirements
Module: addr_fifo_sched

---
 rtl/driver_pkg.sv | 16 +
 rtl/addr_fifo_sched_gen.sv | 42 ++++
 rtl/addr_fifo_sched.sv | 178 +++++++++++++++++
 tb/tb_addr_fifo_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_pkg.sv
// Shared definitions for the vector address scheduler: FSM state encoding
// and default address/count widths.
package driver_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        DRAIN,
        DONE
    } sched_state_e;

endpackage

// File: rtl/addr_fifo_sched_gen.sv
// Incremental vector address generator: load restarts at base, step adds
// the stride and bumps the index, last flags the final index of a pass.
module addr_fifo_sched_gen
    import driver_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  stride_i,
    input  logic [CNT_W-1:0]  vec_cnt_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  idx_q;

    // Load takes priority so a pass restart can coincide with the last step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            addr_q <= base_i;
            idx_q  <= '0;
        end else if (step_i) begin
            addr_q <= addr_q + ADDR_W'(stride_i);
            idx_q  <= idx_q + CNT_W'(1);
        end
    end

    assign addr_o = addr_q;
    assign idx_o  = idx_q;
    assign last_o = (idx_q == (vec_cnt_i - CNT_W'(1)));

endmodule

// File: rtl/addr_fifo_sched.sv
// Address FIFO scheduler: issues base + n*stride addresses with fill-level
// throttling. Define ADDR_FIFO_SCHED_LOOP_EN to add multi-pass looping.
module addr_fifo_sched
    import driver_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_vec_cnt,
    input  logic [CNT_W-1:0]  cfg_stride,
    input  logic [CNT_W-1:0]  cfg_threshold,
`ifdef ADDR_FIFO_SCHED_LOOP_EN
    input  logic [7:0]        cfg_loop_cnt,
`endif
    input  logic [CNT_W-1:0]  words_in_addr_fifo,
    input  logic              addr_fifo_full,
    input  logic              addr_fifo_empty,
    output logic [ADDR_W-1:0] addr_fifo_din,
    output logic              addr_fifo_wr,
    output logic              active_program,
    output logic              end_program,
    output logic [CNT_W-1:0]  issued_cnt
);

    sched_state_e      state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  stride_q;
    logic [CNT_W-1:0]  vec_cnt_q;
    logic [CNT_W-1:0]  thr_q;
    logic [ADDR_W-1:0] din_q;
    logic              wr_q;
    logic              active_q;
    logic              end_q;
    logic [CNT_W-1:0]  issued_q;
`ifdef ADDR_FIFO_SCHED_LOOP_EN
    logic [7:0]        passes_q;
`endif

    logic [CNT_W:0]    fill_sum;
    logic              throttle;
    logic              start_ok;
    logic              write_ok;
    logic              more_passes;
    logic              gen_load;
    logic [ADDR_W-1:0] gen_base;
    logic [ADDR_W-1:0] gen_addr;
    logic [CNT_W-1:0]  gen_idx;
    logic              gen_last;

    // The write already on the bus counts toward the fill it will cause.
    assign fill_sum = {1'b0, words_in_addr_fifo} + {{CNT_W{1'b0}}, wr_q};
    assign throttle = addr_fifo_full
                    | ((thr_q != '0) & (fill_sum >= {1'b0, thr_q}));

    assign start_ok = (state_q == IDLE) & start & ~abort;
    assign write_ok = (state_q == ISSUE) & ~throttle & ~abort;

`ifdef ADDR_FIFO_SCHED_LOOP_EN
    assign more_passes = (passes_q > 8'd1);
`else
    assign more_passes = 1'b0;
`endif

    assign gen_load = start_ok | (write_ok & gen_last & more_passes);
    assign gen_base = (state_q == IDLE) ? cfg_base_addr : base_q;

    addr_fifo_sched_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_gen (
        .clk       (clk),
        .reset     (reset),
        .load_i    (gen_load),
        .step_i    (write_ok),
        .base_i    (gen_base),
        .stride_i  (stride_q),
        .vec_cnt_i (vec_cnt_q),
        .addr_o    (gen_addr),
        .idx_o     (gen_idx),
        .last_o    (gen_last)
    );

    // Program FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            vec_cnt_q <= '0;
            thr_q     <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            active_q  <= 1'b0;
            end_q     <= 1'b0;
            issued_q  <= '0;
`ifdef ADDR_FIFO_SCHED_LOOP_EN
            passes_q  <= 8'd1;
`endif
        end else begin
            wr_q  <= 1'b0;
            end_q <= 1'b0;
            if (abort) begin
                state_q  <= IDLE;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            base_q    <= cfg_base_addr;
                            stride_q  <= cfg_stride;
                            vec_cnt_q <= cfg_vec_cnt;
                            thr_q     <= cfg_threshold;
                            issued_q  <= '0;
`ifdef ADDR_FIFO_SCHED_LOOP_EN
                            passes_q  <= (cfg_loop_cnt == 8'd0) ? 8'd1 : cfg_loop_cnt;
`endif
                            if (cfg_vec_cnt == '0) begin
                                state_q  <= DONE;
                                active_q <= 1'b0;
                            end else begin
                                state_q  <= ISSUE;
                                active_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (throttle) begin
                            state_q <= HOLD;
                        end else begin
                            wr_q     <= 1'b1;
                            din_q    <= gen_addr;
                            issued_q <= gen_idx + CNT_W'(1);
                            if (gen_last && !more_passes) begin
                                state_q <= DRAIN;
                            end
`ifdef ADDR_FIFO_SCHED_LOOP_EN
                            if (gen_last && more_passes) begin
                                passes_q <= passes_q - 8'd1;
                            end
`endif
                        end
                    end
                    HOLD: begin
                        if (!throttle) begin
                            state_q <= ISSUE;
                        end
                    end
                    DRAIN: begin
                        if (addr_fifo_empty) begin
                            state_q  <= DONE;
                            active_q <= 1'b0;
                        end
                    end
                    DONE: begin
                        end_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign addr_fifo_din  = din_q;
    assign addr_fifo_wr   = wr_q;
    assign active_program = active_q;
    assign end_program    = end_q;
    assign issued_cnt     = issued_q;

endmodule

// File: tb/tb_addr_fifo_sched.sv
// Bench for addr_fifo_sched: directed scenarios with literal expectations,
// then randomized programs checked every cycle against a behavioural model.
module tb_addr_fifo_sched;

    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [CNT_W-1:0]  cfg_vec_cnt = '0;
    logic [CNT_W-1:0]  cfg_stride = '0;
    logic [CNT_W-1:0]  cfg_threshold = '0;
`ifdef ADDR_FIFO_SCHED_LOOP_EN
    logic [7:0]        cfg_loop_cnt = 8'd0;
`endif
    logic [CNT_W-1:0]  words_in_addr_fifo;
    logic              addr_fifo_full;
    logic              addr_fifo_empty;
    logic [ADDR_W-1:0] addr_fifo_din;
    logic              addr_fifo_wr;
    logic              active_program;
    logic              end_program;
    logic [CNT_W-1:0]  issued_cnt;

    int fifoFill = 0;
    bit consumerOn = 1'b0;
    int readPct = 100;

    assign words_in_addr_fifo = CNT_W'(fifoFill);
    assign addr_fifo_full     = (fifoFill >= FIFO_DEPTH);
    assign addr_fifo_empty    = (fifoFill == 0);

    always #5 clk = ~clk;

    addr_fifo_sched #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_vec_cnt        (cfg_vec_cnt),
        .cfg_stride         (cfg_stride),
        .cfg_threshold      (cfg_threshold),
`ifdef ADDR_FIFO_SCHED_LOOP_EN
        .cfg_loop_cnt       (cfg_loop_cnt),
`endif
        .words_in_addr_fifo (words_in_addr_fifo),
        .addr_fifo_full     (addr_fifo_full),
        .addr_fifo_empty    (addr_fifo_empty),
        .addr_fifo_din      (addr_fifo_din),
        .addr_fifo_wr       (addr_fifo_wr),
        .active_program     (active_program),
        .end_program        (end_program),
        .issued_cnt         (issued_cnt)
    );

    // Behavioural model state: what the outputs must be after each edge.
    int                mState = M_IDLE;
    bit                mWr = 1'b0;
    logic [ADDR_W-1:0] mDin = '0;
    bit                mActive = 1'b0;
    bit                mEnd = 1'b0;
    int                mIssued = 0;
    logic [ADDR_W-1:0] capBase = '0;
    int                capStride = 0;
    int                capCnt = 0;
    int                capThr = 0;
    int                mIndex = 0;
    int                passesLeft = 1;

    int                assertCount = 0;
    int                failCount = 0;
    int                cycleNo = 0;
    int                startCycle = 0;
    logic [ADDR_W-1:0] seenAddr[$];
    int                seenCycle[$];
    int                endCycle[$];

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", name, cycleNo, act, exp);
        end
    endtask

    // Next-cycle outputs derived from the program rules with plain arithmetic.
    task automatic modelStep();
        bit thr;
        if (!reset) begin
            mState = M_IDLE; mWr = 0; mDin = '0; mActive = 0; mEnd = 0; mIssued = 0;
            return;
        end
        thr = (fifoFill >= FIFO_DEPTH) || (capThr != 0 && (fifoFill + int'(mWr)) >= capThr);
        mWr  = 0;
        mEnd = 0;
        if (abort) begin
            mState = M_IDLE;
        end else begin
            case (mState)
                M_IDLE: if (start) begin
                    capBase   = cfg_base_addr;
                    capStride = int'(cfg_stride);
                    capCnt    = int'(cfg_vec_cnt);
                    capThr    = int'(cfg_threshold);
`ifdef ADDR_FIFO_SCHED_LOOP_EN
                    passesLeft = (cfg_loop_cnt == 8'd0) ? 1 : int'(cfg_loop_cnt);
`else
                    passesLeft = 1;
`endif
                    mIssued = 0;
                    mIndex  = 0;
                    mState  = (capCnt == 0) ? M_DONE : M_ISSUE;
                end
                M_ISSUE: if (thr) begin
                    mState = M_HOLD;
                end else begin
                    mWr  = 1;
                    mDin = capBase + ADDR_W'(longint'(mIndex) * longint'(capStride));
                    mIndex++;
                    mIssued = mIndex;
                    if (mIndex == capCnt) begin
                        if (passesLeft > 1) begin
                            passesLeft--;
                            mIndex = 0;
                        end else begin
                            mState = M_DRAIN;
                        end
                    end
                end
                M_HOLD:  if (!thr) mState = M_ISSUE;
                M_DRAIN: if (fifoFill == 0) mState = M_DONE;
                default: begin
                    mEnd   = 1;
                    mState = M_IDLE;
                end
            endcase
        end
        mActive = (mState == M_ISSUE) || (mState == M_HOLD) || (mState == M_DRAIN);
    endtask

    task automatic checkOutput();
        checkField("wr",     64'(addr_fifo_wr),   64'(mWr));
        checkField("din",    64'(addr_fifo_din),  64'(mDin));
        checkField("active", 64'(active_program), 64'(mActive));
        checkField("end",    64'(end_program),    64'(mEnd));
        checkField("issued", 64'(issued_cnt),     64'(mIssued));
        if (addr_fifo_wr === 1'b1) begin
            seenAddr.push_back(addr_fifo_din);
            seenCycle.push_back(cycleNo);
        end
        if (end_program === 1'b1) endCycle.push_back(cycleNo);
    endtask

    // One clock: model advances on the edge, FIFO absorbs writes, compare on the falling edge.
    task automatic stepCycle();
        int absorbed;
        int drained;
        @(posedge clk);
        absorbed = reset ? int'(mWr) : 0;
        modelStep();
        cycleNo++;
        @(negedge clk);
        drained = 0;
        if (consumerOn && (fifoFill + absorbed) > 0 && $urandom_range(0, 99) < readPct) drained = 1;
        fifoFill = fifoFill + absorbed - drained;
        checkOutput();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic scrambleCfg();
        cfg_base_addr = $urandom();
        cfg_vec_cnt   = CNT_W'($urandom());
        cfg_stride    = CNT_W'($urandom());
        cfg_threshold = CNT_W'($urandom());
    endtask

    task automatic clearLogs();
        seenAddr.delete();
        seenCycle.delete();
        endCycle.delete();
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int stride, input int cnt, input int thr);
        clearLogs();
        cfg_base_addr = base;
        cfg_stride    = CNT_W'(stride);
        cfg_vec_cnt   = CNT_W'(cnt);
        cfg_threshold = CNT_W'(thr);
        start = 1'b1;
        startCycle = cycleNo;
        stepCycle();
        start = 1'b0;
        scrambleCfg();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        runCycles(3);
        checkField("reset_wr",     64'(addr_fifo_wr),   64'd0);
        checkField("reset_din",    64'(addr_fifo_din),  64'd0);
        checkField("reset_active", 64'(active_program), 64'd0);
        checkField("reset_end",    64'(end_program),    64'd0);
        checkField("reset_issued", 64'(issued_cnt),     64'd0);
        reset = 1'b1;
        runCycles(2);

        // Basic three-address program with the FIFO drained immediately.
        consumerOn = 1'b1; readPct = 100;
        applyStimulus(32'h0000_1000, 4, 3, 0);
        runCycles(10);
        checkField("basic_nwrites", 64'(seenAddr.size()), 64'd3);
        if (seenAddr.size() == 3) begin
            checkField("basic_a0", 64'(seenAddr[0]), 64'h1000);
            checkField("basic_a1", 64'(seenAddr[1]), 64'h1004);
            checkField("basic_a2", 64'(seenAddr[2]), 64'h1008);
            checkField("basic_first_lat", 64'(seenCycle[0] - startCycle), 64'd2);
            checkField("basic_span", 64'(seenCycle[2] - seenCycle[0]), 64'd2);
        end
        checkField("basic_nend", 64'(endCycle.size()), 64'd1);
        if (endCycle.size() == 1) checkField("basic_end_lat", 64'(endCycle[0] - startCycle), 64'd6);

        // Empty program completes without writing.
        applyStimulus(32'h0000_5000, 4, 0, 0);
        runCycles(4);
        checkField("zero_nwrites", 64'(seenAddr.size()), 64'd0);
        checkField("zero_nend", 64'(endCycle.size()), 64'd1);
        if (endCycle.size() == 1) checkField("zero_end_lat", 64'(endCycle[0] - startCycle), 64'd2);

        // Threshold of two with no reader: pauses after two writes.
        consumerOn = 1'b0; fifoFill = 0;
        applyStimulus(32'h0000_2000, 4, 10, 2);
        runCycles(8);
        checkField("thr_nwrites", 64'(seenAddr.size()), 64'd2);
        checkField("thr_active", 64'(active_program), 64'd1);
        checkField("thr_wr_idle", 64'(addr_fifo_wr), 64'd0);
        fifoFill = 1;
        runCycles(4);
        checkField("thr_resume_nwrites", 64'(seenAddr.size()), 64'd3);
        if (seenAddr.size() == 3) checkField("thr_resume_addr", 64'(seenAddr[2]), 64'h2008);
        abort = 1'b1; stepCycle(); abort = 1'b0;
        fifoFill = 0; consumerOn = 1'b1;
        runCycles(2);

        // Address wraps modulo 2^32.
        applyStimulus(32'hFFFF_FFFC, 8, 2, 0);
        runCycles(8);
        checkField("wrap_nwrites", 64'(seenAddr.size()), 64'd2);
        if (seenAddr.size() == 2) begin
            checkField("wrap_a0", 64'(seenAddr[0]), 64'hFFFF_FFFC);
            checkField("wrap_a1", 64'(seenAddr[1]), 64'h0000_0004);
        end

        // Abort after two of ten writes.
        applyStimulus(32'h0000_3000, 4, 10, 0);
        runCycles(2);
        abort = 1'b1; stepCycle(); abort = 1'b0;
        checkField("abort_active", 64'(active_program), 64'd0);
        checkField("abort_wr", 64'(addr_fifo_wr), 64'd0);
        runCycles(10);
        checkField("abort_nwrites", 64'(seenAddr.size()), 64'd2);
        checkField("abort_nend", 64'(endCycle.size()), 64'd0);

        // Reset mid-program behaves like abort.
        applyStimulus(32'h0000_3000, 4, 10, 0);
        runCycles(2);
        reset = 1'b0; stepCycle(); reset = 1'b1;
        checkField("rst_active", 64'(active_program), 64'd0);
        checkField("rst_issued", 64'(issued_cnt), 64'd0);
        runCycles(10);
        checkField("rst_nwrites", 64'(seenAddr.size()), 64'd2);
        checkField("rst_nend", 64'(endCycle.size()), 64'd0);

`ifdef ADDR_FIFO_SCHED_LOOP_EN
        // Two passes of two addresses run back-to-back.
        cfg_loop_cnt = 8'd2;
        applyStimulus(32'h0000_0000, 4, 2, 0);
        cfg_loop_cnt = 8'd0;
        runCycles(10);
        checkField("loop_nwrites", 64'(seenAddr.size()), 64'd4);
        if (seenAddr.size() == 4) begin
            checkField("loop_a2", 64'(seenAddr[2]), 64'h0);
            checkField("loop_a3", 64'(seenAddr[3]), 64'h4);
            checkField("loop_span", 64'(seenCycle[3] - seenCycle[0]), 64'd3);
        end
        checkField("loop_nend", 64'(endCycle.size()), 64'd1);
`endif

        // Randomized programs with throttling, stray starts, aborts and cfg churn.
        for (int p = 0; p < 40; p++) begin
            readPct = $urandom_range(20, 100);
`ifdef ADDR_FIFO_SCHED_LOOP_EN
            cfg_loop_cnt = 8'($urandom_range(0, 3));
`endif
            applyStimulus($urandom(),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 32)),
                          int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 6)));
            guard = 0;
            while (mState != M_IDLE && guard < 600) begin
                start = ($urandom_range(0, 9) == 0);
                abort = ($urandom_range(0, 79) == 0);
                scrambleCfg();
                stepCycle();
                guard++;
            end
            start = 1'b0;
            abort = 1'b0;
            checkField("prog_in_budget", 64'(guard < 600), 64'd1);
            runCycles(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
